// File: rtl/symm_fold_sched.sv
// ----------------------------------------------------------------------------
// symm_fold_sched
//
// Purpose:
//   Sits between a signed operand stream and a shared half-range function
//   unit (FU). Each operand is folded onto the non-negative axis before it is
//   issued, and its sign is remembered in an in-order tag FIFO. When the FU
//   returns a result, the matching tag is popped and the result is unfolded
//   using the function's symmetry:
//     SYM_TYPE = 0 (even, f(-x) =  f(x)) : result passes through unchanged
//     SYM_TYPE = 1 (odd,  f(-x) = -f(x)) : result is negated when tag is set
//
// Parameters:
//   M        integer bits including sign (W = M + N)
//   N        fractional bits
//   SYM_TYPE 0 = even function, 1 = odd function
//   DEPTH    maximum operands in flight (power of two, >= 2)
//
// Optional feature macro:
//   SYMM_SAT_EN  When defined, folding the most-negative value -2^(W-1)
//                saturates to 2^(W-1)-1 and pulses 'sat' in the cycle the
//                operand first appears on the FU side; unfold negation of
//                -2^(W-1) also saturates to 2^(W-1)-1. When undefined both
//                operations wrap in two's complement and 'sat' is tied low.
//
// Ports:
//   clk           clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      operand valid
//   in_ready      operand accepted when in_valid && in_ready
//   in_data       signed operand (W bits)
//   fu_valid      folded operand valid toward FU
//   fu_ready      FU accepts when fu_valid && fu_ready
//   fu_data       folded (non-negative) operand
//   fu_rsp_valid  FU result valid, in issue order, no backpressure
//   fu_rsp_data   signed FU result
//   out_valid     unfolded result valid, one-cycle pulse per result
//   out_data      unfolded result
//   inflight      operands accepted whose result has not returned yet
//   sat           one-cycle pulse: operand saturated at fold
//   err           sticky: response received while nothing was in flight
// ----------------------------------------------------------------------------
module symm_fold_sched #(
  parameter int M        = 4,
  parameter int N        = 8,
  parameter int SYM_TYPE = 1,
  parameter int DEPTH    = 4,
  localparam int W       = M + N,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          fu_valid,
  input  logic          fu_ready,
  output logic [W-1:0]  fu_data,
  input  logic          fu_rsp_valid,
  input  logic [W-1:0]  fu_rsp_data,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] inflight,
  output logic          sat,
  output logic          err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef SYMM_SAT_EN
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
`endif

  logic             run_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] tag_mem;

  logic             accept;
  logic             rsp_ok;
  logic             rsp_bad;
  logic             in_neg;
  logic [W-1:0]     in_neg_val;
  logic [W-1:0]     fold_val;
  logic             rsp_neg;
  logic [W-1:0]     rsp_neg_val;
  logic [W-1:0]     unfold_val;

  // run_q holds in_ready low while reset is asserted and until the first
  // clock edge after release, independent of the other registered state.
  assign in_ready = run_q && (!fu_valid || fu_ready) && (inflight < DEPTH_C);
  assign accept   = in_valid && in_ready;

  // A response with nothing in flight has no tag to pair with; it is
  // dropped and only flags the sticky error.
  assign rsp_ok  = fu_rsp_valid && (inflight != '0);
  assign rsp_bad = fu_rsp_valid && (inflight == '0);

  // Fold: absolute value of the incoming operand.
  assign in_neg     = in_data[W-1];
  assign in_neg_val = -in_data;

  // Unfold: only odd functions flip the sign back, and only for operands
  // that were negative when accepted.
  assign rsp_neg     = (SYM_TYPE == 1) && tag_mem[rd_ptr];
  assign rsp_neg_val = -fu_rsp_data;

`ifdef SYMM_SAT_EN
  logic in_min;
  logic rsp_min;

  // The most-negative value has no positive counterpart in W bits, so both
  // directions clamp it to the largest positive value.
  assign in_min     = (in_data == MIN_VAL);
  assign rsp_min    = (fu_rsp_data == MIN_VAL);
  assign fold_val   = in_min ? MAX_VAL : (in_neg ? in_neg_val : in_data);
  assign unfold_val = !rsp_neg ? fu_rsp_data : (rsp_min ? MAX_VAL : rsp_neg_val);
`else
  // Plain two's complement wrap: -2^(W-1) maps onto itself.
  assign fold_val   = in_neg ? in_neg_val : in_data;
  assign unfold_val = rsp_neg ? rsp_neg_val : fu_rsp_data;
`endif

  // Ready qualifier: low in reset, high from the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Issue register: loaded with the folded operand on accept and held
  // stable until the FU takes it. A new accept can only happen when the
  // register is empty or draining this cycle, so load wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_valid <= 1'b0;
      fu_data  <= '0;
      sat      <= 1'b0;
    end else begin
      if (accept) begin
        fu_valid <= 1'b1;
        fu_data  <= fold_val;
      end else if (fu_ready) begin
        fu_valid <= 1'b0;
      end
`ifdef SYMM_SAT_EN
      // Registered alongside fu_data so the pulse lines up with the first
      // cycle the clamped operand is presented to the FU.
      sat <= accept && in_min;
`else
      sat <= 1'b0;
`endif
    end
  end

  // Tag FIFO: one sign bit per accepted operand, popped in issue order by
  // each valid response. Pointers wrap naturally because DEPTH is a power
  // of two. Writes never hit the slot being read because an accept is only
  // possible while at least one slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_mem <= '0;
    end else begin
      if (accept) begin
        tag_mem[wr_ptr] <= in_neg;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (rsp_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Credit counter: accepts add one, paired responses remove one. A
  // response freeing a credit only raises in_ready from the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept, rsp_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky error for orphan responses; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (rsp_bad) begin
      err <= 1'b1;
    end
  end

  // Result register: out_valid pulses for exactly one cycle per paired
  // response; out_data keeps the last result between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= rsp_ok;
      if (rsp_ok) begin
        out_data <= unfold_val;
      end
    end
  end

endmodule

// File: tb/tb_symm_fold_sched.sv
// ----------------------------------------------------------------------------
// tb_symm_fold_sched
//
// Self-checking bench for symm_fold_sched. Two instances share all inputs:
// 'dut' is the odd-symmetry build, 'dut_e' the even-symmetry build. A
// behavioural model tracks signs in a queue and computes folded / unfolded
// values with integer arithmetic; a bench-side FU echoes every operand it
// takes back as its response, in order. Honours SYMM_SAT_EN if defined.
// ----------------------------------------------------------------------------
module tb_symm_fold_sched;

  localparam int M     = 4;
  localparam int N     = 8;
  localparam int W     = M + N;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int MAXP  = (1 << (W - 1)) - 1;

`ifdef SYMM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          fu_ready;
  logic          fu_rsp_valid;
  logic [W-1:0]  fu_rsp_data;

  logic          in_ready,   e_in_ready;
  logic          fu_valid,   e_fu_valid;
  logic [W-1:0]  fu_data,    e_fu_data;
  logic          out_valid,  e_out_valid;
  logic [W-1:0]  out_data,   e_out_data;
  logic [CW-1:0] inflight,   e_inflight;
  logic          sat,        e_sat;
  logic          err,        e_err;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  bit           m_run;
  bit           m_fu_valid;
  logic [W-1:0] m_fu_data;
  bit           m_out_valid;
  logic [W-1:0] m_out_data;
  logic [W-1:0] m_out_data_e;
  bit           m_sat;
  bit           m_err;
  int           m_inflight;
  bit           m_acc;
  bit           m_tags[$];
  logic [W-1:0] fu_q[$];

  always #5 clk = ~clk;

  symm_fold_sched #(.M(M), .N(N), .SYM_TYPE(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_data(fu_data),
    .fu_rsp_valid(fu_rsp_valid), .fu_rsp_data(fu_rsp_data),
    .out_valid(out_valid), .out_data(out_data),
    .inflight(inflight), .sat(sat), .err(err)
  );

  symm_fold_sched #(.M(M), .N(N), .SYM_TYPE(0), .DEPTH(DEPTH)) dut_e (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_data(in_data),
    .fu_valid(e_fu_valid), .fu_ready(fu_ready), .fu_data(e_fu_data),
    .fu_rsp_valid(fu_rsp_valid), .fu_rsp_data(fu_rsp_data),
    .out_valid(e_out_valid), .out_data(e_out_data),
    .inflight(e_inflight), .sat(e_sat), .err(e_err)
  );

  // |x| as an integer, clamped or wrapped back into W bits
  function automatic logic [W-1:0] fold_ref(input logic [W-1:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = -v;
    if (v > MAXP && SAT) v = MAXP;
    return v[W-1:0];
  endfunction

  // Negate for odd functions on negative operands, clamp or wrap to W bits
  function automatic logic [W-1:0] unfold_ref(input logic [W-1:0] r, input bit neg, input bit odd);
    int v;
    v = $signed(r);
    if (odd && neg) v = -v;
    if (v > MAXP && SAT) v = MAXP;
    return v[W-1:0];
  endfunction

  task automatic model_reset();
    m_run = 0; m_fu_valid = 0; m_fu_data = '0; m_out_valid = 0;
    m_out_data = '0; m_out_data_e = '0; m_sat = 0; m_err = 0;
    m_inflight = 0; m_acc = 0;
    m_tags.delete();
    fu_q.delete();
  endtask

  // One clock edge; the model advances on the same input values the DUT saw
  task automatic tick();
    bit ready, fire, acc, tag;
    ready = m_run && (!m_fu_valid || fu_ready) && (m_inflight < DEPTH);
    acc   = in_valid && ready;
    fire  = m_fu_valid && fu_ready;
    @(posedge clk);
    #1;
    if (fire) fu_q.push_back(m_fu_data);
    m_out_valid = 0;
    if (fu_rsp_valid) begin
      if (m_inflight == 0) begin
        m_err = 1;
      end else begin
        tag = m_tags.pop_front();
        m_out_valid  = 1;
        m_out_data   = unfold_ref(fu_rsp_data, tag, 1'b1);
        m_out_data_e = unfold_ref(fu_rsp_data, tag, 1'b0);
        m_inflight--;
      end
    end
    m_sat = 0;
    if (acc) begin
      m_tags.push_back(in_data[W-1]);
      m_fu_data  = fold_ref(in_data);
      m_fu_valid = 1;
      m_sat      = SAT && (in_data == 12'h800);
      m_inflight++;
    end else if (fire) begin
      m_fu_valid = 0;
    end
    m_acc = acc;
    m_run = 1;
  endtask

  // Bench FU: echoes taken operands back when asked
  task automatic drive_rsp(input bit want);
    if (want && fu_q.size() > 0) begin
      fu_rsp_valid = 1'b1;
      fu_rsp_data  = fu_q.pop_front();
    end else begin
      fu_rsp_valid = 1'b0;
      fu_rsp_data  = 12'($urandom);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    fu_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (m_inflight == 0 && fu_q.size() == 0) break;
      drive_rsp(1'b1);
      tick();
    end
    fu_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 0; in_data = '0; fu_ready = 0; fu_rsp_valid = 0; fu_rsp_data = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %b want 0", in_ready); end
    vectors++; if (fu_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_fu_valid: got %b want 0", fu_valid); end
    vectors++; if (fu_data !== 12'h000) begin miscompares++; $display("[TB] FAIL rst_fu_data: got %h want 000", fu_data); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 12'h000) begin miscompares++; $display("[TB] FAIL rst_out_data: got %h want 000", out_data); end
    vectors++; if (inflight !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_inflight: got %0d want 0", inflight); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_sat: got %b want 0", sat); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_err: got %b want 0", err); end
    rst_n = 1'b1;
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_odd_even();
    in_valid = 1; in_data = 12'hF00; fu_ready = 0;
    tick();
    in_valid = 0;
    vectors++; if (fu_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL fold_valid: got %b want 1", fu_valid); end
    vectors++; if (fu_data !== 12'h100) begin miscompares++; $display("[TB] FAIL fold_odd_data: got %h want 100", fu_data); end
    vectors++; if (e_fu_data !== 12'h100) begin miscompares++; $display("[TB] FAIL fold_even_data: got %h want 100", e_fu_data); end
    fu_ready = 1;
    tick();
    drive_rsp(1'b1);
    fu_rsp_data = 12'h0B5;
    tick();
    fu_rsp_valid = 0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL unfold_valid: got %b want 1", out_valid); end
    vectors++; if (out_data !== 12'hF4B) begin miscompares++; $display("[TB] FAIL unfold_odd_neg: got %h want F4B", out_data); end
    vectors++; if (e_out_data !== 12'h0B5) begin miscompares++; $display("[TB] FAIL unfold_even_neg: got %h want 0B5", e_out_data); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL out_pulse: got %b want 0", out_valid); end
    in_valid = 1; in_data = 12'h100;
    tick();
    in_valid = 0;
    vectors++; if (fu_data !== 12'h100) begin miscompares++; $display("[TB] FAIL fold_pos: got %h want 100", fu_data); end
    tick();
    drive_rsp(1'b1);
    fu_rsp_data = 12'h0B5;
    tick();
    fu_rsp_valid = 0;
    vectors++; if (out_data !== 12'h0B5) begin miscompares++; $display("[TB] FAIL unfold_odd_pos: got %h want 0B5", out_data); end
    vectors++; if (e_out_data !== 12'h0B5) begin miscompares++; $display("[TB] FAIL unfold_even_pos: got %h want 0B5", e_out_data); end
  endtask

  task automatic test_credit();
    fu_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 12'($urandom);
      tick();
    end
    in_data = 12'($urandom);
    vectors++; if (inflight !== 3'd4) begin miscompares++; $display("[TB] FAIL credit_full_count: got %0d want 4", inflight); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL credit_full_ready: got %b want 0", in_ready); end
    tick();
    vectors++; if (inflight !== 3'd4) begin miscompares++; $display("[TB] FAIL credit_hold: got %0d want 4", inflight); end
    drive_rsp(1'b1);
    tick();
    vectors++; if (inflight !== 3'd3) begin miscompares++; $display("[TB] FAIL credit_free_count: got %0d want 3", inflight); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL credit_free_ready: got %b want 1", in_ready); end
    vectors++; if (out_data !== m_out_data) begin miscompares++; $display("[TB] FAIL credit_rsp_data: got %h want %h", out_data, m_out_data); end
    drive_rsp(1'b1);
    tick();
    vectors++; if (inflight !== 3'd3) begin miscompares++; $display("[TB] FAIL credit_simul: got %0d want 3", inflight); end
    fu_rsp_valid = 0;
    tick();
    in_valid = 0;
    vectors++; if (inflight !== 3'd4) begin miscompares++; $display("[TB] FAIL credit_refill: got %0d want 4", inflight); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL credit_refill_ready: got %b want 0", in_ready); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    fu_ready = 0;
    in_valid = 1; in_data = 12'($urandom);
    held = fold_ref(in_data);
    tick();
    in_data = 12'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (fu_data !== held) begin miscompares++; $display("[TB] FAIL bp_stable_%0d: got %h want %h", i, fu_data, held); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready_%0d: got %b want 0", i, in_ready); end
      vectors++; if (inflight !== 3'd1) begin miscompares++; $display("[TB] FAIL bp_count_%0d: got %0d want 1", i, inflight); end
    end
    drain();
  endtask

  // Eight mixed-sign operands through a randomly stalling FU; results must
  // come back as the original values (odd) or their magnitudes (even).
  task automatic test_order();
    int ops[8];
    int exp_q[$];
    int k, got, v, e;
    for (int i = 0; i < 8; i++) begin
      v = $urandom_range(1, MAXP);
      ops[i] = (i % 2 == 0) ? -v : (($urandom % 2) ? -v : v);
    end
    k = 0; got = 0;
    for (int c = 0; c < 300 && got < 8; c++) begin
      in_valid = (k < 8) && ($urandom % 4 != 0);
      if (k < 8) in_data = ops[k][W-1:0];
      fu_ready = ($urandom % 3 != 0);
      drive_rsp($urandom % 2 == 1);
      tick();
      if (m_acc) begin exp_q.push_back(ops[k]); k++; end
      vectors++; if (out_valid !== m_out_valid) begin miscompares++; $display("[TB] FAIL order_valid: got %b want %b", out_valid, m_out_valid); end
      if (m_out_valid) begin
        e = exp_q.pop_front();
        got++;
        vectors++; if (out_data !== e[W-1:0]) begin miscompares++; $display("[TB] FAIL order_odd_%0d: got %h want %h", got, out_data, e[W-1:0]); end
        if (e < 0) e = -e;
        vectors++; if (e_out_data !== e[W-1:0]) begin miscompares++; $display("[TB] FAIL order_even_%0d: got %h want %h", got, e_out_data, e[W-1:0]); end
      end
    end
    vectors++; if (got != 8) begin miscompares++; $display("[TB] FAIL order_timeout: got %0d results want 8", got); end
    drain();
  endtask

  task automatic test_saturation();
    logic [W-1:0] want_fold;
    want_fold = SAT ? 12'h7FF : 12'h800;
    fu_ready = 0;
    in_valid = 1; in_data = 12'h800;
    tick();
    in_valid = 0;
    vectors++; if (fu_data !== want_fold) begin miscompares++; $display("[TB] FAIL sat_fold: got %h want %h", fu_data, want_fold); end
    vectors++; if (sat !== SAT) begin miscompares++; $display("[TB] FAIL sat_pulse: got %b want %b", sat, SAT); end
    tick();
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_one_cycle: got %b want 0", sat); end
    fu_ready = 1;
    tick();
    drive_rsp(1'b1);
    fu_rsp_data = 12'h800;
    tick();
    fu_rsp_valid = 0;
    vectors++; if (out_data !== want_fold) begin miscompares++; $display("[TB] FAIL sat_unfold: got %h want %h", out_data, want_fold); end
    vectors++; if (e_out_data !== 12'h800) begin miscompares++; $display("[TB] FAIL sat_unfold_even: got %h want 800", e_out_data); end
  endtask

  task automatic test_random();
    bit exp_ready;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom % 3 != 0);
      in_data  = ($urandom % 16 == 0) ? 12'h800 : 12'($urandom);
      fu_ready = ($urandom % 4 != 0);
      drive_rsp($urandom % 3 != 0);
      #1;
      exp_ready = m_run && (!m_fu_valid || fu_ready) && (m_inflight < DEPTH);
      vectors++; if (in_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL rnd_ready@%0d: got %b want %b", c, in_ready, exp_ready); end
      tick();
      vectors++; if (inflight !== CW'(m_inflight)) begin miscompares++; $display("[TB] FAIL rnd_inflight@%0d: got %0d want %0d", c, inflight, m_inflight); end
      vectors++; if (fu_valid !== m_fu_valid) begin miscompares++; $display("[TB] FAIL rnd_fu_valid@%0d: got %b want %b", c, fu_valid, m_fu_valid); end
      if (m_fu_valid) begin
        vectors++; if (fu_data !== m_fu_data) begin miscompares++; $display("[TB] FAIL rnd_fu_data@%0d: got %h want %h", c, fu_data, m_fu_data); end
      end
      vectors++; if (sat !== m_sat) begin miscompares++; $display("[TB] FAIL rnd_sat@%0d: got %b want %b", c, sat, m_sat); end
      vectors++; if (out_valid !== m_out_valid) begin miscompares++; $display("[TB] FAIL rnd_out_valid@%0d: got %b want %b", c, out_valid, m_out_valid); end
      if (m_out_valid) begin
        vectors++; if (out_data !== m_out_data) begin miscompares++; $display("[TB] FAIL rnd_out_odd@%0d: got %h want %h", c, out_data, m_out_data); end
        vectors++; if (e_out_data !== m_out_data_e) begin miscompares++; $display("[TB] FAIL rnd_out_even@%0d: got %h want %h", c, e_out_data, m_out_data_e); end
      end
      vectors++; if (err !== m_err) begin miscompares++; $display("[TB] FAIL rnd_err@%0d: got %b want %b", c, err, m_err); end
    end
    drain();
  endtask

  task automatic test_error();
    vectors++; if (inflight !== 3'd0) begin miscompares++; $display("[TB] FAIL err_precond: got %0d want 0", inflight); end
    fu_rsp_valid = 1; fu_rsp_data = 12'($urandom);
    tick();
    fu_rsp_valid = 0;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_set: got %b want 1", err); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL err_no_out: got %b want 0", out_valid); end
    vectors++; if (inflight !== 3'd0) begin miscompares++; $display("[TB] FAIL err_count: got %0d want 0", inflight); end
    tick();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_async_reset();
    fu_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 12'($urandom);
      tick();
    end
    drive_rsp(1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (fu_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_fu_valid: got %b want 0", fu_valid); end
    vectors++; if (fu_data !== 12'h000) begin miscompares++; $display("[TB] FAIL ar_fu_data: got %h want 000", fu_data); end
    vectors++; if (inflight !== 3'd0) begin miscompares++; $display("[TB] FAIL ar_inflight: got %0d want 0", inflight); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_in_ready: got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 12'h000) begin miscompares++; $display("[TB] FAIL ar_out_data: got %h want 000", out_data); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_err: got %b want 0", err); end
    do_reset();
    rst_n = 1'b1;
    tick();
    fu_rsp_valid = 1; fu_rsp_data = 12'($urandom);
    tick();
    fu_rsp_valid = 0;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL ar_late_rsp_err: got %b want 1", err); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_late_rsp_out: got %b want 0", out_valid); end
  endtask

  initial begin
    $display("[TB] symm_fold_sched bench start (saturation %0d)", SAT);
    test_reset();
    test_odd_even();
    test_credit();
    test_backpressure();
    test_order();
    test_saturation();
    test_random();
    test_error();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
